// File: rtl/rob_n.sv
`default_nettype none
//==============================================================================
// Module   : rob_n
// Purpose  : Circular reorder buffer with WIDTH-wide in-order allocate/retire
//            and NUM_CDB completion channels.
// Option   : ROB_CDB_BYPASS_EN - a head-window entry completing on the CDB
//            retires in the same cycle, data taken from the CDB.
// Revision : 1.0 - initial release
//==============================================================================
module rob_n #(
  parameter  int DEPTH   = 16,
  parameter  int WIDTH   = 2,
  parameter  int NUM_CDB = 3,
  parameter  int PREG_W  = 6,
  parameter  int DATA_W  = 32,
  localparam int TAG_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          alloc_valid,
  input  logic [WIDTH-1:0]          alloc_is_store,
  input  logic [WIDTH*PREG_W-1:0]   alloc_pd,
  input  logic [WIDTH*PREG_W-1:0]   alloc_old_pd,
  output logic                      alloc_ready,
  output logic [WIDTH*TAG_W-1:0]    alloc_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic [WIDTH-1:0]          retire_valid,
  output logic [WIDTH-1:0]          retire_is_store,
  output logic [WIDTH*PREG_W-1:0]   retire_pd,
  output logic [WIDTH*PREG_W-1:0]   retire_old_pd,
  output logic [WIDTH*DATA_W-1:0]   retire_data,
  output logic [CNT_W-1:0]          count
);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_width = CNT_W'(WIDTH);

  // Entry state
  logic [DEPTH-1:0]  r_v;
  logic [DEPTH-1:0]  r_comp;
  logic [DEPTH-1:0]  r_is_store;
  logic [PREG_W-1:0] r_pd     [DEPTH];
  logic [PREG_W-1:0] r_old_pd [DEPTH];
  logic [DATA_W-1:0] r_result [DEPTH];
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  // Completion decode
  logic [DEPTH-1:0]  w_cdb_hit;
  logic [DATA_W-1:0] w_cdb_res [DEPTH];
  logic [DEPTH-1:0]  w_done;

  // Allocation
  logic              w_alloc_go;
  logic [CNT_W-1:0]  w_alloc_cnt;
  logic [CNT_W-1:0]  w_alloc_add;
  logic [TAG_W-1:0]  w_alloc_idx [WIDTH];

  // Retirement
  logic              w_ret_run;
  logic [WIDTH-1:0]  w_ret;
  logic [CNT_W-1:0]  w_ret_cnt;
  logic [TAG_W-1:0]  w_ret_idx  [WIDTH];
  logic [DATA_W-1:0] w_ret_data [WIDTH];

  assign alloc_ready = (c_depth - r_count) >= c_width;
  assign count       = r_count;

  // Per-entry CDB match; scanning high to low lets the lowest channel win.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_cdb_hit[e] = 1'b0;
      w_cdb_res[e] = '0;
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == TAG_W'(e))) begin
          w_cdb_hit[e] = 1'b1;
          w_cdb_res[e] = cdb_data[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Compacted lane tags: each lane takes tail plus the number of valid lanes below it.
  always_comb begin
    w_alloc_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_alloc_idx[i] = r_tail + w_alloc_cnt[TAG_W-1:0];
      if (alloc_valid[i]) begin
        w_alloc_cnt = w_alloc_cnt + CNT_W'(1);
      end
    end
  end

  assign w_alloc_go  = alloc_ready & ~flush;
  assign w_alloc_add = w_alloc_go ? w_alloc_cnt : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_tag
    assign alloc_tag[i*TAG_W +: TAG_W] = w_alloc_idx[i];
  end

`ifdef ROB_CDB_BYPASS_EN
  assign w_done = r_comp | (r_v & w_cdb_hit);

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      w_ret_data[k] = r_comp[w_ret_idx[k]] ? r_result[w_ret_idx[k]]
                                           : w_cdb_res[w_ret_idx[k]];
    end
  end
`else
  assign w_done = r_comp;

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      w_ret_data[k] = r_result[w_ret_idx[k]];
    end
  end
`endif

  // In-order retirement window; the chain breaks at the first not-ready entry.
  always_comb begin
    w_ret_run = ~flush;
    w_ret_cnt = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_ret_idx[k] = r_head + TAG_W'(k);
      w_ret_run    = w_ret_run & r_v[w_ret_idx[k]] & w_done[w_ret_idx[k]];
      w_ret[k]     = w_ret_run;
      if (w_ret_run) begin
        w_ret_cnt = w_ret_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_ret
    assign retire_valid[k]                    = w_ret[k];
    assign retire_is_store[k]                 = w_ret[k] & r_is_store[w_ret_idx[k]];
    assign retire_pd[k*PREG_W +: PREG_W]      = w_ret[k] ? r_pd[w_ret_idx[k]]     : '0;
    assign retire_old_pd[k*PREG_W +: PREG_W]  = w_ret[k] ? r_old_pd[w_ret_idx[k]] : '0;
    assign retire_data[k*DATA_W +: DATA_W]    = w_ret[k] ? w_ret_data[k]          : '0;
  end

  // Control state. Update order: completion, then retire clear, then allocate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_comp  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_v     <= '0;
      r_comp  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (r_v[e] && w_cdb_hit[e]) begin
          r_comp[e] <= 1'b1;
        end
      end
      for (int k = 0; k < WIDTH; k++) begin
        if (w_ret[k]) begin
          r_v[w_ret_idx[k]]    <= 1'b0;
          r_comp[w_ret_idx[k]] <= 1'b0;
        end
      end
      if (w_alloc_go) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (alloc_valid[i]) begin
            r_v[w_alloc_idx[i]]    <= 1'b1;
            r_comp[w_alloc_idx[i]] <= 1'b0;
          end
        end
      end
      r_head  <= r_head + w_ret_cnt[TAG_W-1:0];
      r_tail  <= r_tail + w_alloc_add[TAG_W-1:0];
      r_count <= r_count + w_alloc_add - w_ret_cnt;
    end
  end

  // Payload fields carry no reset; they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (r_v[e] && w_cdb_hit[e]) begin
        r_result[e] <= w_cdb_res[e];
      end
    end
    if (w_alloc_go) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (alloc_valid[i]) begin
          r_is_store[w_alloc_idx[i]] <= alloc_is_store[i];
          r_pd[w_alloc_idx[i]]       <= alloc_pd[i*PREG_W +: PREG_W];
          r_old_pd[w_alloc_idx[i]]   <= alloc_old_pd[i*PREG_W +: PREG_W];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_n.sv
`default_nettype none
//==============================================================================
// Module   : tb_rob_n
// Purpose  : Directed scoreboard bench for rob_n (default parameters).
// Revision : 1.0 - initial release
//==============================================================================
module tb_rob_n;
  localparam int DEPTH   = 16;
  localparam int WIDTH   = 2;
  localparam int NUM_CDB = 3;
  localparam int PREG_W  = 6;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int CNT_W   = 5;
`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      flush;
  logic [WIDTH-1:0]          alloc_valid;
  logic [WIDTH-1:0]          alloc_is_store;
  logic [WIDTH*PREG_W-1:0]   alloc_pd;
  logic [WIDTH*PREG_W-1:0]   alloc_old_pd;
  logic                      alloc_ready;
  logic [WIDTH*TAG_W-1:0]    alloc_tag;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic [WIDTH-1:0]          retire_valid;
  logic [WIDTH-1:0]          retire_is_store;
  logic [WIDTH*PREG_W-1:0]   retire_pd;
  logic [WIDTH*PREG_W-1:0]   retire_old_pd;
  logic [WIDTH*DATA_W-1:0]   retire_data;
  logic [CNT_W-1:0]          count;

  rob_n #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_CDB(NUM_CDB), .PREG_W(PREG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
    .alloc_pd(alloc_pd), .alloc_old_pd(alloc_old_pd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .retire_valid(retire_valid), .retire_is_store(retire_is_store),
    .retire_pd(retire_pd), .retire_old_pd(retire_old_pd),
    .retire_data(retire_data), .count(count)
  );

  always #5 clk = ~clk;

  int                n_tests = 0;
  int                n_fail  = 0;
  int                sb_q[$];
  int                m_tail  = 0;
  int                mon_tag;
  logic [PREG_W-1:0] exp_pd   [DEPTH];
  logic [PREG_W-1:0] exp_old  [DEPTH];
  logic              exp_st   [DEPTH];
  logic [DATA_W-1:0] exp_data [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush          = 1'b0;
    alloc_valid    = '0;
    alloc_is_store = '0;
    alloc_pd       = '0;
    alloc_old_pd   = '0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    cdb_data       = '0;
  endtask

  task automatic set_cdb(input int ch, input int tag, input logic [DATA_W-1:0] d, input bit upd);
    cdb_valid[ch]                  = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W]     = TAG_W'(tag);
    cdb_data[ch*DATA_W +: DATA_W]  = d;
    if (upd) exp_data[tag] = d;
  endtask

  // Drives an allocation, checks ready and the compacted tags, records accepted lanes.
  task automatic do_alloc(input logic [WIDTH-1:0] mask, input bit acc, input int seed);
    int off;
    int t;
    off = 0;
    alloc_valid = mask;
    for (int l = 0; l < WIDTH; l++) begin
      t = (m_tail + off) % DEPTH;
      alloc_pd[l*PREG_W +: PREG_W]     = PREG_W'((t * 5 + seed) & 63);
      alloc_old_pd[l*PREG_W +: PREG_W] = PREG_W'((t * 3 + seed + 1) & 63);
      alloc_is_store[l]                = 1'((t + seed) & 1);
      if (mask[l]) off++;
    end
    #1;
    check("alloc_ready", 64'(alloc_ready), 64'(acc));
    off = 0;
    for (int l = 0; l < WIDTH; l++) begin
      t = (m_tail + off) % DEPTH;
      check($sformatf("alloc_tag lane%0d", l), 64'(alloc_tag[l*TAG_W +: TAG_W]), 64'(t));
      if (acc && mask[l]) begin
        exp_pd[t]   = PREG_W'((t * 5 + seed) & 63);
        exp_old[t]  = PREG_W'((t * 3 + seed + 1) & 63);
        exp_st[t]   = 1'((t + seed) & 1);
        exp_data[t] = '0;
        sb_q.push_back(t);
      end
      if (mask[l]) off++;
    end
    if (acc) m_tail = (m_tail + off) % DEPTH;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    idle();
    while (count != 0 && n < 20) begin
      tick();
      n++;
    end
    check(name, 64'(count), 64'd0);
  endtask

  // Monitor: every presented retirement is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < WIDTH; k++) begin
        n_tests++;
        if (retire_valid[k]) begin
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL retire lane%0d unexpected: got pd=0x%0h data=0x%0h, expected no retirement",
                     k, retire_pd[k*PREG_W +: PREG_W], retire_data[k*DATA_W +: DATA_W]);
          end else begin
            mon_tag = sb_q.pop_front();
            if (retire_pd[k*PREG_W +: PREG_W] !== exp_pd[mon_tag] ||
                retire_old_pd[k*PREG_W +: PREG_W] !== exp_old[mon_tag] ||
                retire_is_store[k] !== exp_st[mon_tag] ||
                retire_data[k*DATA_W +: DATA_W] !== exp_data[mon_tag]) begin
              n_fail++;
              $display("FAIL retire lane%0d tag%0d: got pd=%0h old=%0h st=%0b data=%0h, expected pd=%0h old=%0h st=%0b data=%0h",
                       k, mon_tag, retire_pd[k*PREG_W +: PREG_W], retire_old_pd[k*PREG_W +: PREG_W],
                       retire_is_store[k], retire_data[k*DATA_W +: DATA_W],
                       exp_pd[mon_tag], exp_old[mon_tag], exp_st[mon_tag], exp_data[mon_tag]);
            end
          end
        end else if (retire_pd[k*PREG_W +: PREG_W] !== '0 || retire_old_pd[k*PREG_W +: PREG_W] !== '0 ||
                     retire_is_store[k] !== 1'b0 || retire_data[k*DATA_W +: DATA_W] !== '0) begin
          n_fail++;
          $display("FAIL idle lane%0d fields: got pd=%0h old=%0h st=%0b data=%0h, expected all zero",
                   k, retire_pd[k*PREG_W +: PREG_W], retire_old_pd[k*PREG_W +: PREG_W],
                   retire_is_store[k], retire_data[k*DATA_W +: DATA_W]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    check("reset count", 64'(count), 64'd0);
    check("reset alloc_ready", 64'(alloc_ready), 64'd1);
    check("reset retire_valid", 64'(retire_valid), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Fill to full: tags 0..15 in order, then allocation is refused
    for (int i = 0; i < 8; i++) begin
      idle(); do_alloc(2'b11, 1'b1, 1); tick();
    end
    check("full count", 64'(count), 64'd16);
    check("full alloc_ready", 64'(alloc_ready), 64'd0);
    idle(); do_alloc(2'b11, 1'b0, 1); tick();
    check("full count after refused alloc", 64'(count), 64'd16);

    // Flush while the head would otherwise retire, alloc asserted in the flush cycle
    idle(); set_cdb(0, 0, 32'hC0DE_0000, 1'b1); tick();
    idle(); flush = 1'b1; alloc_valid = 2'b11; #1;
    check("flush retire_valid", 64'(retire_valid), 64'd0);
    sb_q.delete(); m_tail = 0;
    tick();
    idle(); #1;
    check("post-flush count", 64'(count), 64'd0);
    check("post-flush alloc_ready", 64'(alloc_ready), 64'd1);
    check("post-flush tail", 64'(alloc_tag[TAG_W-1:0]), 64'd0);

    // count=14, allocate 2 and retire 2 in one cycle, tail wraps
    for (int i = 0; i < 7; i++) begin
      idle(); do_alloc(2'b11, 1'b1, 3); tick();
    end
    check("count 14", 64'(count), 64'd14);
`ifdef ROB_CDB_BYPASS_EN
    idle(); set_cdb(0, 0, 32'h3700_0000, 1'b1); set_cdb(1, 1, 32'h3700_0001, 1'b1);
    do_alloc(2'b11, 1'b1, 3);
    check("wrap retire_valid", 64'(retire_valid), 64'd3);
    tick();
`else
    idle(); set_cdb(0, 0, 32'h3700_0000, 1'b1); set_cdb(1, 1, 32'h3700_0001, 1'b1); #1;
    check("cdb cycle retire_valid", 64'(retire_valid), 64'd0);
    tick();
    idle(); do_alloc(2'b11, 1'b1, 3);
    check("wrap retire_valid", 64'(retire_valid), 64'd3);
    tick();
`endif
    idle(); #1;
    check("wrap count", 64'(count), 64'd14);
    check("wrap alloc_ready", 64'(alloc_ready), 64'd1);
    check("wrap tail", 64'(alloc_tag[TAG_W-1:0]), 64'd0);

    // Drain tags 2..15 through all three channels
    for (int t = 2; t < 16; t += 3) begin
      idle();
      for (int ch = 0; ch < NUM_CDB; ch++) begin
        if (t + ch < 16) set_cdb(ch, t + ch, 32'hE000_0000 | 32'(t + ch), 1'b1);
      end
      tick();
    end
    wait_empty("drain after wrap");

    // Head incomplete blocks younger completed entries
    idle(); do_alloc(2'b11, 1'b1, 5); tick();
    idle(); do_alloc(2'b11, 1'b1, 5); tick();
    idle(); set_cdb(0, 1, 32'h0000_0011, 1'b1); set_cdb(1, 2, 32'h0000_0022, 1'b1);
    set_cdb(2, 3, 32'h0000_0033, 1'b1); #1;
    check("head-block retire_valid a", 64'(retire_valid), 64'd0);
    tick();
    idle(); #1;
    check("head-block retire_valid b", 64'(retire_valid), 64'd0);
    tick();
    idle(); set_cdb(0, 0, 32'h0000_0000 | 32'h00AB_CDEF, 1'b1); #1;
    check("head complete cycle", 64'(retire_valid), BYP ? 64'd3 : 64'd0);
    tick();
    idle(); #1;
    check("head complete +1", 64'(retire_valid), 64'd3);
    tick();
    idle(); #1;
    check("head complete +2", 64'(retire_valid), BYP ? 64'd0 : 64'd3);
    tick();
    idle(); #1;
    check("head complete +3", 64'(retire_valid), 64'd0);
    check("head complete count", 64'(count), 64'd0);

    // Two channels to one tag: channel 0 wins; strobe to an empty entry ignored
    idle(); do_alloc(2'b11, 1'b1, 7); tick();
    idle(); do_alloc(2'b11, 1'b1, 7); tick();
    idle(); set_cdb(0, 5, 32'hAAAA_0000, 1'b1); set_cdb(2, 5, 32'h0000_5555, 1'b0);
    set_cdb(1, 9, 32'h0000_0BAD, 1'b0); tick();
    idle(); set_cdb(0, 4, 32'h0404_0404, 1'b1); set_cdb(1, 6, 32'h0606_0606, 1'b1);
    set_cdb(2, 7, 32'h0707_0707, 1'b1); tick();
    wait_empty("drain after priority");
    idle(); do_alloc(2'b11, 1'b1, 9); tick();
    idle(); #1;
    check("stale strobe retire_valid", 64'(retire_valid), 64'd0);
    tick();
    check("stale strobe count", 64'(count), 64'd2);
    idle(); set_cdb(0, 8, 32'h0808_0808, 1'b1); set_cdb(1, 9, 32'h0909_0909, 1'b1); tick();
    wait_empty("drain after stale");

    // Single-lane allocation and compaction, then head completion latency
    idle(); do_alloc(2'b01, 1'b1, 2); tick();
    idle(); do_alloc(2'b10, 1'b1, 2); tick();
    check("compaction count", 64'(count), 64'd2);
    idle(); set_cdb(0, 10, 32'h0000_1234, 1'b1); #1;
    check("bypass cycle retire_valid", 64'(retire_valid), BYP ? 64'd1 : 64'd0);
    tick();
    idle(); #1;
    check("bypass cycle+1 retire_valid", 64'(retire_valid), BYP ? 64'd0 : 64'd1);
    tick();
    idle(); set_cdb(0, 11, 32'h0000_0B0B, 1'b1); tick();
    wait_empty("drain after latency");

    // count=6, flush with alloc asserted
    for (int i = 0; i < 3; i++) begin
      idle(); do_alloc(2'b11, 1'b1, 4); tick();
    end
    check("count 6", 64'(count), 64'd6);
    idle(); flush = 1'b1; alloc_valid = 2'b11; set_cdb(0, 12, 32'h1212_1212, 1'b0); #1;
    check("flush2 retire_valid", 64'(retire_valid), 64'd0);
    sb_q.delete(); m_tail = 0;
    tick();
    idle(); #1;
    check("flush2 count", 64'(count), 64'd0);
    check("flush2 alloc_ready", 64'(alloc_ready), 64'd1);
    check("flush2 tail", 64'(alloc_tag[TAG_W-1:0]), 64'd0);
    check("flush2 retire_valid after", 64'(retire_valid), 64'd0);

    // Asynchronous reset mid-fill
    idle(); do_alloc(2'b11, 1'b1, 6); tick();
    idle(); do_alloc(2'b11, 1'b1, 6);
    rst_n = 1'b0;
    #1;
    check("async reset count", 64'(count), 64'd0);
    check("async reset alloc_ready", 64'(alloc_ready), 64'd1);
    check("async reset retire_valid", 64'(retire_valid), 64'd0);
    sb_q.delete(); m_tail = 0;
    tick();
    idle(); tick();
    rst_n = 1'b1;
    idle(); do_alloc(2'b11, 1'b1, 8); tick();
    check("post-reset count", 64'(count), 64'd2);
    idle(); set_cdb(0, 0, 32'hF000_0000, 1'b1); set_cdb(1, 1, 32'hF000_0001, 1'b1); tick();
    wait_empty("final drain");
    tick();
    check("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_n.md
ROB_N -- requirements
Module: rob_n

Interface
REQ-001 Parameter DEPTH, 16, number of ROB entries; power of two, 4..64.
REQ-002 Parameter WIDTH, 2, allocate/retire lanes per cycle; 1..4.
REQ-003 Parameter NUM_CDB, 3, completion (CDB) channels; 1..4.
REQ-004 Parameter PREG_W, 6, physical register index width.
REQ-005 Parameter DATA_W, 32, result width.
REQ-006 TAG_W SHALL equal clog2(DEPTH).
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 flush  in  1  synchronous discard of all entries.
REQ-010 alloc_valid  in  WIDTH  per-lane allocate request.
REQ-011 alloc_is_store  in  WIDTH  per-lane type: 0 register write, 1 memory write.
REQ-012 alloc_pd  in  WIDTH*PREG_W  per-lane destination physical register.
REQ-013 alloc_old_pd  in  WIDTH*PREG_W  per-lane previous mapping of the architectural destination.
REQ-014 alloc_ready  out  1  all WIDTH lanes may allocate this cycle.
REQ-015 alloc_tag  out  WIDTH*TAG_W  per-lane assigned entry index.
REQ-016 cdb_valid  in  NUM_CDB  per-channel completion strobe.
REQ-017 cdb_tag  in  NUM_CDB*TAG_W  per-channel completing entry.
REQ-018 cdb_data  in  NUM_CDB*DATA_W  per-channel result.
REQ-019 retire_valid  out  WIDTH  per-lane retirement this cycle; lanes contiguous from lane 0.
REQ-020 retire_is_store, retire_pd, retire_old_pd, retire_data  out  WIDTH x (1, PREG_W, PREG_W, DATA_W)  retired entry fields; retire_old_pd goes to the free pool.
REQ-021 count  out  clog2(DEPTH+1)  occupied entries.

Function
REQ-022 Circular buffer: head, tail pointers wrap modulo DEPTH; fields per entry: v, is_store, pd, old_pd, result, comp.
REQ-023 alloc_ready SHALL be 1 when DEPTH - count >= WIDTH, from registered count only; same-cycle retirement does not raise it.
REQ-024 Allocation accepted only when alloc_ready=1; accepted lanes are compacted: lane i gets tail + (valid lanes below i), sets v=1, comp=0; tail advances by popcount(alloc_valid).
REQ-025 alloc_tag SHALL be valid combinationally in the request cycle, independent of alloc_valid.
REQ-026 A CDB strobe sets comp=1 and writes result at the next edge; strobes to an entry with v=0 are ignored; two channels to one tag: lowest channel index wins.
REQ-027 Retire: up to WIDTH entries from head, in order, stopping at the first entry with comp=0 or v=0; retired entries clear v; head advances by retired count; no backpressure.
REQ-028 Retire outputs are combinational from entry state; unused lanes drive retire_valid=0 and zero fields.
REQ-029 count(t+1) = count + allocated - retired; allocate and retire in the same cycle are both honoured.
REQ-030 flush SHALL clear all v, comp, head, tail and count at the next edge; same-cycle alloc, CDB and retire are discarded, and retire_valid is forced 0 during flush.

Reset
REQ-031 rst_n low SHALL immediately force head=tail=0, count=0, all v=0 and comp=0, hence alloc_ready=1 and retire_valid=0; result, pd and old_pd need no reset.
REQ-032 Reset asserted mid-operation discards all entries; the first edge after deassertion behaves as an empty ROB.

Configuration
REQ-033 Macro ROB_CDB_BYPASS_EN defined: a head-window entry completing on the CDB in cycle t SHALL retire in cycle t with retire_data taken from cdb_data.
REQ-034 ROB_CDB_BYPASS_EN undefined: an entry completing in cycle t retires at the earliest in cycle t+1.

Verification
REQ-035 Reset, then alloc_valid=2'b11 for 8 cycles, no CDB, DEPTH=16 -> tags 0..15 issued in order, count=16, alloc_ready=0 from then on.
REQ-036 Fill 4 entries, CDB tags 1,2,3 complete, tag 0 not -> retire_valid=0; then complete tag 0 -> retire tags 0,1 next cycle, tags 2,3 the cycle after.
REQ-037 count=14, alloc 2 and retire 2 in the same cycle -> count stays 14, tail wraps to 0 correctly, alloc_ready=1 again.
REQ-038 cdb_valid=3'b101, both with tag 5, data 0xAAAA0000 (ch0) and 0x5555 (ch2) -> entry 5 holds 0xAAAA0000.
REQ-039 count=6, flush with alloc_valid=11 -> next cycle count=0, head=tail=0, retire_valid=0; rst_n low mid-fill -> count=0 with no clock edge.
REQ-040 Head entry completes via CDB with data 0x1234: with ROB_CDB_BYPASS_EN -> retire in the same cycle, retire_data=0x1234; without it -> retire one cycle later.
